// File: rtl/lcd_serial_pkg.sv
// lcd_serial_pkg: shared state encoding, frame field layout and error codes
// for the LCD serial slave.
package lcd_serial_pkg;
    typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;
    localparam int ADR_W      = 6;
    localparam int RSV_W      = 2;
    localparam int DAT_W      = 8;
    localparam int FRAME_BITS = 16;
    localparam int DAT_LSB    = 0;
    localparam int RSV_LSB    = DAT_LSB + DAT_W;
    localparam int ADR_LSB    = RSV_LSB + RSV_W;
    localparam int REG_NUM    = 1 << ADR_W;
    localparam int BCNT_W     = 5;
    localparam logic [BCNT_W-1:0] BCNT_FULL = 5'd16;
    localparam logic [BCNT_W-1:0] BCNT_MAX  = 5'd17;
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_SHORT = 2'b01;
    localparam logic [1:0] ERR_LONG  = 2'b10;
    localparam logic [1:0] ERR_RSV   = 2'b11;
endpackage

// File: rtl/lcd_serial_slave_if.sv
// lcd_serial_slave_if: serial pins plus the register-file read/write status bus.
interface lcd_serial_slave_if;
    import lcd_serial_pkg::*;
    logic              lcd_scen_i;
    logic              lcd_scl_i;
    logic              lcd_sda_i;
    logic [ADR_W-1:0]  rd_adr_i;
    logic [DAT_W-1:0]  rd_dat_o;
    logic              wr_stb_o;
    logic [ADR_W-1:0]  wr_adr_o;
    logic [DAT_W-1:0]  wr_dat_o;
    logic              frame_err_o;
    logic [1:0]        err_code_o;
    logic [15:0]       frame_cnt_o;
    logic              busy_o;
    modport slave (
        input  lcd_scen_i, lcd_scl_i, lcd_sda_i, rd_adr_i,
        output rd_dat_o, wr_stb_o, wr_adr_o, wr_dat_o, frame_err_o, err_code_o, frame_cnt_o, busy_o
    );
    modport master (
        output lcd_scen_i, lcd_scl_i, lcd_sda_i, rd_adr_i,
        input  rd_dat_o, wr_stb_o, wr_adr_o, wr_dat_o, frame_err_o, err_code_o, frame_cnt_o, busy_o
    );
endinterface

// File: rtl/lcd_sync_edge.sv
// lcd_sync_edge: multi-stage synchronizer with registered level and edge flags;
// level and edge flags are aligned so a rise/fall flag coincides with the new level.
module lcd_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic i_d,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[STAGES-1] & r_prev;
        end
    assign o_lvl  = r_prev;
    assign o_rise = r_rise;
    assign o_fall = r_fall;
endmodule

// File: rtl/lcd_serial_slave.sv
// lcd_serial_slave: 16-bit serial frame receiver writing a 64x8 register file,
// with frame classification, error reporting and a good-frame counter.
module lcd_serial_slave
    import lcd_serial_pkg::*;
#(
    parameter int         SYNC_STAGES   = 2,
    parameter logic [7:0] REG_RESET_VAL = 8'h00
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    lcd_serial_slave_if.slave  bus
);
    state_t                r_state;
    state_t                w_state_nxt;
    logic [SYNC_STAGES:0]  r_warm;
    logic [BCNT_W-1:0]     r_bcnt;
    logic [FRAME_BITS-1:0] r_sr;
    logic [DAT_W-1:0]      r_regs [REG_NUM];
    logic [DAT_W-1:0]      r_rd_dat;
    logic                  r_wr_stb;
    logic [ADR_W-1:0]      r_wr_adr;
    logic [DAT_W-1:0]      r_wr_dat;
    logic                  r_frame_err;
    logic [1:0]            r_err_code;
    logic [15:0]           r_frame_cnt;
    logic w_scen, w_scen_rise, w_scen_fall;
    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_unused;
    logic w_warm, w_shift, w_commit, w_good, w_bad;
    logic [1:0]       w_err;
    logic [ADR_W-1:0] w_adr;
    logic [DAT_W-1:0] w_dat;
    logic [RSV_W-1:0] w_rsv;
    lcd_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scen (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .i_d(bus.lcd_scen_i),
        .o_lvl(w_scen), .o_rise(w_scen_rise), .o_fall(w_scen_fall)
    );
    lcd_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_scl (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .i_d(bus.lcd_scl_i),
        .o_lvl(w_scl_lvl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );
    lcd_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sda (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .i_d(bus.lcd_sda_i),
        .o_lvl(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );
    assign w_unused = &{1'b0, w_scl_lvl, w_scl_fall, w_sda_rise, w_sda_fall};
    // Reset-value ones must drain from the synchronizers before scen can be trusted.
    assign w_warm   = r_warm[SYNC_STAGES];
    assign w_shift  = (r_state == ST_SHIFT) && w_scl_rise && !w_scen;
    assign w_commit = (r_state == ST_COMMIT);
    assign w_adr    = r_sr[ADR_LSB +: ADR_W];
    assign w_dat    = r_sr[DAT_LSB +: DAT_W];
    assign w_rsv    = r_sr[RSV_LSB +: RSV_W];
    assign w_err    = (r_bcnt == BCNT_MAX)  ? ERR_LONG  :
                      (r_bcnt <  BCNT_FULL) ? ERR_SHORT :
                      (w_rsv != '0)         ? ERR_RSV   : ERR_NONE;
    assign w_good   = w_commit && (w_err == ERR_NONE);
    assign w_bad    = w_commit && (w_err != ERR_NONE);
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            r_state <= ST_SYNC;
            r_warm  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_warm  <= {r_warm[SYNC_STAGES-1:0], 1'b1};
        end
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SYNC:  w_state_nxt = (w_warm && w_scen) ? ST_IDLE : ST_SYNC;
            ST_IDLE:  w_state_nxt = w_scen_fall ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: w_state_nxt = w_scen_rise ? ST_COMMIT : ST_SHIFT;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            r_bcnt      <= '0;
            r_sr        <= '0;
            r_wr_stb    <= 1'b0;
            r_wr_adr    <= '0;
            r_wr_dat    <= '0;
            r_frame_err <= 1'b0;
            r_err_code  <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_bcnt      <= (r_state == ST_IDLE) ? '0 :
                           (w_shift && r_bcnt != BCNT_MAX) ? r_bcnt + 5'd1 : r_bcnt;
            r_sr        <= w_shift ? {r_sr[FRAME_BITS-2:0], w_sda} : r_sr;
            r_wr_stb    <= w_good;
            r_frame_err <= w_bad;
            r_wr_adr    <= w_good ? w_adr : r_wr_adr;
            r_wr_dat    <= w_good ? w_dat : r_wr_dat;
            r_frame_cnt <= w_good ? r_frame_cnt + 16'd1 : r_frame_cnt;
            r_err_code  <= w_bad ? w_err : r_err_code;
        end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i)
            for (int i = 0; i < REG_NUM; i++) r_regs[i] <= REG_RESET_VAL;
        else if (w_good)
            r_regs[w_adr] <= w_dat;
    // Read samples the array before a same-edge write lands: old value first, new next cycle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) r_rd_dat <= '0;
        else          r_rd_dat <= r_regs[bus.rd_adr_i];
    assign bus.rd_dat_o    = r_rd_dat;
    assign bus.wr_stb_o    = r_wr_stb;
    assign bus.wr_adr_o    = r_wr_adr;
    assign bus.wr_dat_o    = r_wr_dat;
    assign bus.frame_err_o = r_frame_err;
    assign bus.err_code_o  = r_err_code;
    assign bus.frame_cnt_o = r_frame_cnt;
    assign bus.busy_o      = (r_state == ST_SHIFT) || (r_state == ST_COMMIT);
endmodule
